chan_wr_ctl: RTL
================

# chan_wr_ctl

Parametrised SPI command/data router for the NeoPixel LED controller. It sits between the SPI slave byte interface and the configuration register file plus the per-channel pixel RAMs, and steers each received byte to the right destination. It generalises the fixed 16-channel RGB router with parametrised channel count, RAM depth and bytes-per-pixel, plus a start-channel select command. It also latches frame geometry at the command byte and reports command/select/overflow errors.

## Interface
Parameters:
- CHAN_NUM, 16: number of channel RAMs (2..32); CW = $clog2(CHAN_NUM)
- ADDR_W, 8: pixel RAM address width
- BPP, 3: data bytes per pixel (3 = GRB, 4 = GRBW)
- REG_NUM, 8: config registers; RW = $clog2(REG_NUM)

Ports (reset rst_n_i, asynchronous, active-low; clock clk_i):
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- dc_i  in  1  0 = command byte, 1 = data byte; qualified by spi_byte_vld_i
- spi_byte_vld_i  in  1  one-cycle byte strobe
- spi_byte_data_i  in  8  received byte
- reg_chan_len_i  in  ADDR_W  last pixel index per channel
- reg_chan_cnt_i  in  CW  last channel index
- reg_rd_addr_o  out  RW  config read pointer
- reg_wr_en_o  out  1  config write strobe
- reg_wr_addr_o  out  RW  config write address
- ram_wr_en_o  out  CHAN_NUM  one-hot RAM write strobe
- ram_wr_addr_o  out  ADDR_W  pixel address
- ram_wr_byte_en_o  out  BPP+1  bit BPP = address lane; bits BPP-1:0 = colour lanes, MSB first
- ram_wr_done_o  out  1  frame-complete pulse
- err_o  out  3  one-cycle pulses {overflow, bad select, bad command}

## Operation
- Commands (dc_i=0): 0x2a CONF_WR, 0x2b ADDR_WR, 0x2c DATA_WR, 0x2d CONF_RD, 0x2e CHAN_SEL. Any other value -> state IDLE, err_o[0] pulse.
- Every accepted command byte clears pixel/reg pointers and aborts the current frame without ram_wr_done_o.
- ADDR_WR/DATA_WR latch reg_chan_len_i, reg_chan_cnt_i and start_chan into len_q, last_q, chan_q. Later input changes have no effect until the next command.
- States: IDLE, CONF_WR, CONF_RD, CHAN_SEL, ADDR_WR, DATA_WR, FULL.
- CONF_WR: each data byte -> reg_wr_en_o; reg_wr_addr_o then increments mod 2^RW.
- CONF_RD: each data byte increments reg_rd_addr_o mod 2^RW. Output value is reset/cleared to 0 at the command.
- CHAN_SEL: first data byte b. If b <= reg_chan_cnt_i: start_chan <= b. Else err_o[1] pulse and start_chan is unchanged. State -> IDLE. start_chan resets to 0 and persists across frames.
- ADDR_WR: one byte per pixel; byte_en = 1<<BPP.
- DATA_WR: BPP bytes per pixel; lane one-hot starts at bit BPP-1 and rotates right. The pixel address increments after lane 0.
- Pixel complete at ram_wr_addr_o == len_q: address wraps to 0 and chan_q increments.
- Channel complete at chan_q == last_q: ram_wr_done_o pulses and state -> FULL.
- FULL: data bytes produce no writes and pulse err_o[2]. Exit only on a command.
- IDLE: data bytes are ignored silently.
- Outputs outside active states: ram_wr_en_o = 0 and byte_en = 0.

## Timing
- Strobes are combinational in the cycle of the byte: reg_wr_en_o, ram_wr_en_o, ram_wr_done_o and err_o = spi_byte_vld_i & decode of the current registered state.
- Pointers, lanes and state update on the clk_i edge ending that cycle. Address and lane for a byte are therefore stable while its strobe is high.
- Zero latency; back-to-back strobes every cycle are supported.
- Bad command: err_o[0] in the same cycle as the command byte.
- Reset values: all outputs 0, state IDLE, start_chan 0. Reset mid-frame discards the frame with no done pulse.
- len_q = 0 means one pixel per channel.
- Byte with spi_byte_vld_i=0: no state change.

## Structure
- Package chan_wr_pkg:
  - cmd_t enum (0x2a..0x2e)
  - state_t enum
  - err bit index constants
- Sub-module chan_lane_seq: pixel address, lane rotation and channel counter. Emits pix_done and frame_done.
- Top module: command decode, FSM, error and strobe logic.

## Test plan
- CONF_WR, then 10 data bytes -> 10 reg_wr_en_o pulses; addresses 0..7,0,1.
- len=2, cnt=1, BPP=3; DATA_WR, then 18 bytes:
  - byte_en cycles 4,2,1; addresses 0,0,0,1,1,1,2,2,2
  - ram_wr_en_o 0x1 for bytes 1-9, 0x2 for bytes 10-18
  - ram_wr_done_o pulses with byte 18
  - byte 19 -> err_o=3'b100, no write
- CHAN_SEL 0x05 with cnt=7, then ADDR_WR and 3 bytes, len=2:
  - ram_wr_en_o=0x20, byte_en=8, addresses 0..2
  - next byte writes channel 6
- CHAN_SEL 0x09 with cnt=7 -> err_o=3'b010; start_chan unchanged.
- DATA_WR with 4 bytes, then command 0x55:
  - err_o=3'b001, no done pulse
  - following data bytes ignored
- Frame geometry latching: change reg_chan_len_i mid-frame -> geometry unchanged. Assert rst_n_i low mid-frame -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/chan_wr_pkg.sv
// Shared types for the SPI command/data router: command opcodes, FSM states
// and err_o bit positions.
package chan_wr_pkg;

  typedef enum logic [7:0] {
    CmdConfWr  = 8'h2a,
    CmdAddrWr  = 8'h2b,
    CmdDataWr  = 8'h2c,
    CmdConfRd  = 8'h2d,
    CmdChanSel = 8'h2e
  } cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StConfWr,
    StConfRd,
    StChanSel,
    StAddrWr,
    StDataWr,
    StFull
  } state_t;

  localparam int unsigned ErrCmd = 0;
  localparam int unsigned ErrSel = 1;
  localparam int unsigned ErrOvf = 2;

endpackage

// File: rtl/chan_wr_ctl_if.sv
// Byte-stream, register-file and pixel-RAM signals of the router. The master side
// owns the SPI byte stream and the configuration registers; the slave is the router.
interface chan_wr_ctl_if #(
  parameter int unsigned CHAN_NUM = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned BPP      = 3,
  parameter int unsigned REG_NUM  = 8
);
  localparam int unsigned CW = $clog2(CHAN_NUM);
  localparam int unsigned RW = $clog2(REG_NUM);

  logic                dc_i;
  logic                spi_byte_vld_i;
  logic [7:0]          spi_byte_data_i;
  logic [ADDR_W-1:0]   reg_chan_len_i;
  logic [CW-1:0]       reg_chan_cnt_i;
  logic [RW-1:0]       reg_rd_addr_o;
  logic                reg_wr_en_o;
  logic [RW-1:0]       reg_wr_addr_o;
  logic [CHAN_NUM-1:0] ram_wr_en_o;
  logic [ADDR_W-1:0]   ram_wr_addr_o;
  logic [BPP:0]        ram_wr_byte_en_o;
  logic                ram_wr_done_o;
  logic [2:0]          err_o;

  modport master (
    output dc_i, spi_byte_vld_i, spi_byte_data_i, reg_chan_len_i, reg_chan_cnt_i,
    input  reg_rd_addr_o, reg_wr_en_o, reg_wr_addr_o, ram_wr_en_o, ram_wr_addr_o,
           ram_wr_byte_en_o, ram_wr_done_o, err_o
  );

  modport slave (
    input  dc_i, spi_byte_vld_i, spi_byte_data_i, reg_chan_len_i, reg_chan_cnt_i,
    output reg_rd_addr_o, reg_wr_en_o, reg_wr_addr_o, ram_wr_en_o, ram_wr_addr_o,
           ram_wr_byte_en_o, ram_wr_done_o, err_o
  );

endinterface

// File: rtl/chan_lane_seq.sv
// Pixel address, colour-lane rotation and channel counter for one frame.
// Geometry is captured on load_i and held until the next load.
module chan_lane_seq #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BPP    = 3,
  parameter int unsigned CW     = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              addr_mode_i,
  input  logic [CW-1:0]     start_chan_i,
  input  logic [CW-1:0]     last_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [BPP-1:0]    lane_o,
  output logic [CW-1:0]     chan_o,
  output logic              pix_done_o,
  output logic              frame_done_o
);

  localparam logic [BPP-1:0] LaneFirst = {1'b1, {(BPP-1){1'b0}}};

  logic [ADDR_W-1:0] addr_q, addr_d, len_q, len_d;
  logic [BPP-1:0]    lane_q, lane_d;
  logic [CW-1:0]     chan_q, chan_d, last_q, last_d;
  logic              pix_last;

  // Address mode carries one byte per pixel, so every byte ends a pixel.
  assign pix_last     = addr_mode_i | lane_q[0];
  assign pix_done_o   = step_i & pix_last & (addr_q == len_q);
  assign frame_done_o = pix_done_o & (chan_q == last_q);

  assign addr_o = addr_q;
  assign lane_o = lane_q;
  assign chan_o = chan_q;

  always_comb begin
    addr_d = addr_q;
    lane_d = lane_q;
    chan_d = chan_q;
    len_d  = len_q;
    last_d = last_q;
    if (clr_i) begin
      addr_d = '0;
      lane_d = LaneFirst;
      if (load_i) begin
        len_d  = len_i;
        last_d = last_i;
        chan_d = start_chan_i;
      end
    end else if (step_i) begin
      if (!addr_mode_i) begin
        lane_d = {lane_q[0], lane_q[BPP-1:1]};
      end
      if (pix_last) begin
        if (addr_q == len_q) begin
          addr_d = '0;
          chan_d = chan_q + CW'(1);
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q <= '0;
      lane_q <= LaneFirst;
      chan_q <= '0;
      len_q  <= '0;
      last_q <= '0;
    end else begin
      addr_q <= addr_d;
      lane_q <= lane_d;
      chan_q <= chan_d;
      len_q  <= len_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/chan_wr_ctl.sv
// SPI command/data router: decodes command bytes, steers data bytes to the config
// register file or the per-channel pixel RAMs, and flags command/select/overflow errors.
module chan_wr_ctl
  import chan_wr_pkg::*;
#(
  parameter int unsigned CHAN_NUM = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned BPP      = 3,
  parameter int unsigned REG_NUM  = 8
) (
  input logic          clk_i,
  input logic          rst_n_i,
  chan_wr_ctl_if.slave bus_io
);

  localparam int unsigned CW = $clog2(CHAN_NUM);
  localparam int unsigned RW = $clog2(REG_NUM);

  state_t            state_q, state_d;
  logic [CW-1:0]     start_chan_q, start_chan_d;
  logic [RW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              cmd_vld, data_vld, cmd_acc, frame_load, step;
  logic              reg_wen, ram_done, pix_done, frame_done;
  logic [CHAN_NUM-1:0] ram_en;
  logic [BPP:0]      byte_en;
  logic [2:0]        err;
  logic [ADDR_W-1:0] pix_addr;
  logic [BPP-1:0]    lane;
  logic [CW-1:0]     chan;

  assign cmd_vld  = bus_io.spi_byte_vld_i & ~bus_io.dc_i;
  assign data_vld = bus_io.spi_byte_vld_i & bus_io.dc_i;
  assign step     = data_vld & ((state_q == StAddrWr) | (state_q == StDataWr));

  chan_lane_seq #(
    .ADDR_W(ADDR_W),
    .BPP   (BPP),
    .CW    (CW)
  ) u_seq (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clr_i       (cmd_acc),
    .load_i      (frame_load),
    .step_i      (step),
    .addr_mode_i (state_q == StAddrWr),
    .start_chan_i(start_chan_q),
    .last_i      (bus_io.reg_chan_cnt_i),
    .len_i       (bus_io.reg_chan_len_i),
    .addr_o      (pix_addr),
    .lane_o      (lane),
    .chan_o      (chan),
    .pix_done_o  (pix_done),
    .frame_done_o(frame_done)
  );

  always_comb begin
    state_d      = state_q;
    start_chan_d = start_chan_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cmd_acc      = 1'b0;
    frame_load   = 1'b0;
    reg_wen      = 1'b0;
    ram_en       = '0;
    ram_done     = 1'b0;
    err          = '0;
    if (cmd_vld) begin
      cmd_acc = 1'b1;
      case (bus_io.spi_byte_data_i)
        CmdConfWr:  state_d = StConfWr;
        CmdConfRd:  state_d = StConfRd;
        CmdChanSel: state_d = StChanSel;
        CmdAddrWr: begin
          state_d    = StAddrWr;
          frame_load = 1'b1;
        end
        CmdDataWr: begin
          state_d    = StDataWr;
          frame_load = 1'b1;
        end
        default: begin
          cmd_acc     = 1'b0;
          state_d     = StIdle;
          err[ErrCmd] = 1'b1;
        end
      endcase
      if (cmd_acc) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
    end else if (data_vld) begin
      unique case (state_q)
        StConfWr: begin
          reg_wen  = 1'b1;
          wr_ptr_d = wr_ptr_q + RW'(1);
        end
        StConfRd: rd_ptr_d = rd_ptr_q + RW'(1);
        StChanSel: begin
          if (bus_io.spi_byte_data_i <= 8'(bus_io.reg_chan_cnt_i)) begin
            start_chan_d = bus_io.spi_byte_data_i[CW-1:0];
          end else begin
            err[ErrSel] = 1'b1;
          end
          state_d = StIdle;
        end
        StAddrWr, StDataWr: begin
          ram_en = {{(CHAN_NUM-1){1'b0}}, 1'b1} << chan;
          if (pix_done && frame_done) begin
            ram_done = 1'b1;
            state_d  = StFull;
          end
        end
        StFull:  err[ErrOvf] = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_en = '0;
    if (state_q == StAddrWr) begin
      byte_en = {1'b1, {BPP{1'b0}}};
    end else if (state_q == StDataWr) begin
      byte_en = {1'b0, lane};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      start_chan_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      start_chan_q <= start_chan_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  assign bus_io.reg_rd_addr_o    = rd_ptr_q;
  assign bus_io.reg_wr_en_o      = reg_wen;
  assign bus_io.reg_wr_addr_o    = wr_ptr_q;
  assign bus_io.ram_wr_en_o      = ram_en;
  assign bus_io.ram_wr_addr_o    = pix_addr;
  assign bus_io.ram_wr_byte_en_o = byte_en;
  assign bus_io.ram_wr_done_o    = ram_done;
  assign bus_io.err_o            = err;

endmodule
